// File: rtl/reg_file_rename.sv
// reg_file_rename
// Architectural register file with a per-register rename tag. The decoder
// reads source operands (a value, or the ROB tag of the pending producer) and
// renames destinations to freshly allocated ROB tags; the ROB commits results
// and can flush all rename state on a mispredict. Register 0 is hardwired to
// zero. Tag 0 means "no producer pending, value is architectural".
//
// Optional build macro: REGFILE_DEBUG_EN
//   Adds a combinational debug read port (no forwarding) and a free-running
//   32-bit count of accepted commits to non-zero registers.
module reg_file_rename #(
    parameter int REG_NUM   = 32,
    parameter int REG_IDX_W = 5,
    parameter int ROB_TAG_W = 4,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic [REG_IDX_W-1:0] in_decoder_rs1,
    output logic [DATA_W-1:0]    out_decoder_value1,
    output logic [ROB_TAG_W-1:0] out_decoder_tag1,
    input  logic [REG_IDX_W-1:0] in_decoder_rs2,
    output logic [DATA_W-1:0]    out_decoder_value2,
    output logic [ROB_TAG_W-1:0] out_decoder_tag2,
    input  logic                 in_decoder_rename_flag,
    input  logic [REG_IDX_W-1:0] in_decoder_rd,
    input  logic [ROB_TAG_W-1:0] in_decoder_rob_tag,
    input  logic [REG_IDX_W-1:0] in_rob_commit_index,
    input  logic [ROB_TAG_W-1:0] in_rob_commit_tag,
    input  logic [DATA_W-1:0]    in_rob_commit_value,
    input  logic                 in_rob_xbp
`ifdef REGFILE_DEBUG_EN
    ,
    input  logic [REG_IDX_W-1:0] in_dbg_index,
    output logic [DATA_W-1:0]    out_dbg_value,
    output logic [31:0]          out_dbg_commit_cnt
`endif
);

    // Architectural state: committed values and the tag of the youngest
    // in-flight producer of each register.
    logic [DATA_W-1:0]    value_q [REG_NUM];
    logic [ROB_TAG_W-1:0] tag_q   [REG_NUM];
    logic [DATA_W-1:0]    value_d [REG_NUM];
    logic [ROB_TAG_W-1:0] tag_d   [REG_NUM];

    logic commit_en;
    logic rename_en;

    // A commit bypasses onto a read only when it retires the very producer the
    // register is still waiting on; a commit from an older producer whose tag
    // was superseded by a younger rename must not unblock the reader.
    function automatic logic fwd_hit(
        input logic [REG_IDX_W-1:0] rs,
        input logic [REG_IDX_W-1:0] commit_idx,
        input logic [ROB_TAG_W-1:0] commit_tag,
        input logic [ROB_TAG_W-1:0] cur_tag
    );
        return (rs != '0) && (commit_idx == rs) &&
               (cur_tag == commit_tag) && (cur_tag != '0);
    endfunction

    assign commit_en = (in_rob_commit_index != '0);
    assign rename_en = in_decoder_rename_flag && (in_decoder_rd != '0) && !in_rob_xbp;

    // Source 1 read: x0 is zero, matching commit forwards, else stored state.
    always_comb begin
        out_decoder_value1 = '0;
        out_decoder_tag1   = '0;
        if (in_decoder_rs1 != '0) begin
            if (fwd_hit(in_decoder_rs1, in_rob_commit_index, in_rob_commit_tag,
                        tag_q[in_decoder_rs1])) begin
                out_decoder_value1 = in_rob_commit_value;
            end else begin
                out_decoder_value1 = value_q[in_decoder_rs1];
                out_decoder_tag1   = tag_q[in_decoder_rs1];
            end
        end
    end

    // Source 2 read: same rules as source 1.
    always_comb begin
        out_decoder_value2 = '0;
        out_decoder_tag2   = '0;
        if (in_decoder_rs2 != '0) begin
            if (fwd_hit(in_decoder_rs2, in_rob_commit_index, in_rob_commit_tag,
                        tag_q[in_decoder_rs2])) begin
                out_decoder_value2 = in_rob_commit_value;
            end else begin
                out_decoder_value2 = value_q[in_decoder_rs2];
                out_decoder_tag2   = tag_q[in_decoder_rs2];
            end
        end
    end

    // Next state: commit first, then flush or rename; later steps override
    // earlier ones on the same tag (rename beats the commit tag-clear, flush
    // clears everything but leaves the committed value in place).
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        if (commit_en) begin
            value_d[in_rob_commit_index] = in_rob_commit_value;
            if (tag_q[in_rob_commit_index] == in_rob_commit_tag) begin
                tag_d[in_rob_commit_index] = '0;
            end
        end
        if (in_rob_xbp) begin
            for (int i = 0; i < REG_NUM; i++) begin
                tag_d[i] = '0;
            end
        end else if (rename_en) begin
            tag_d[in_decoder_rd] = in_decoder_rob_tag;
        end
    end

    // State register: synchronous active-low reset clears everything; rdy low
    // freezes the file.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else if (rdy) begin
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end

`ifdef REGFILE_DEBUG_EN
    logic [31:0] dbg_cnt_q;

    assign out_dbg_value      = value_q[in_dbg_index];
    assign out_dbg_commit_cnt = dbg_cnt_q;

    // Count accepted commits to real registers; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dbg_cnt_q <= '0;
        end else if (rdy && commit_en) begin
            dbg_cnt_q <= dbg_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reg_file_rename.sv
// Testbench for reg_file_rename: directed scenarios followed by randomized
// traffic, checked against a behavioural register-file model through a
// scoreboard queue drained by an independent monitor.
module tb_reg_file_rename;

    localparam int REG_NUM   = 32;
    localparam int REG_IDX_W = 5;
    localparam int ROB_TAG_W = 4;
    localparam int DATA_W    = 32;

    logic                 clk;
    logic                 rst;
    logic                 rdy;
    logic [REG_IDX_W-1:0] rs1, rs2, rd, commit_index;
    logic [DATA_W-1:0]    value1, value2, commit_value;
    logic [ROB_TAG_W-1:0] tag1, tag2, rob_tag, commit_tag;
    logic                 rename_flag, xbp;
`ifdef REGFILE_DEBUG_EN
    logic [REG_IDX_W-1:0] dbg_index;
    logic [DATA_W-1:0]    dbg_value;
    logic [31:0]          dbg_commit_cnt;
`endif

    reg_file_rename #(
        .REG_NUM(REG_NUM), .REG_IDX_W(REG_IDX_W), .ROB_TAG_W(ROB_TAG_W), .DATA_W(DATA_W)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .rdy                   (rdy),
        .in_decoder_rs1        (rs1),
        .out_decoder_value1    (value1),
        .out_decoder_tag1      (tag1),
        .in_decoder_rs2        (rs2),
        .out_decoder_value2    (value2),
        .out_decoder_tag2      (tag2),
        .in_decoder_rename_flag(rename_flag),
        .in_decoder_rd         (rd),
        .in_decoder_rob_tag    (rob_tag),
        .in_rob_commit_index   (commit_index),
        .in_rob_commit_tag     (commit_tag),
        .in_rob_commit_value   (commit_value),
        .in_rob_xbp            (xbp)
`ifdef REGFILE_DEBUG_EN
        ,
        .in_dbg_index          (dbg_index),
        .out_dbg_value         (dbg_value),
        .out_dbg_commit_cnt    (dbg_commit_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0]    v1;
        logic [ROB_TAG_W-1:0] t1;
        logic [DATA_W-1:0]    v2;
        logic [ROB_TAG_W-1:0] t2;
        int                   id;
    } exp_t;

    exp_t q[$];

    // Reference model: what each architectural register holds and which ROB
    // entry (0 = none) will eventually produce it.
    logic [DATA_W-1:0]    m_val [REG_NUM];
    logic [ROB_TAG_W-1:0] m_tag [REG_NUM];

    int  checks = 0;
    int  errors = 0;
    int  step_id = 0;
    bit  stim_done = 1'b0;

    // A source read as the decoder sees it this cycle.
    task automatic model_read(input logic [REG_IDX_W-1:0] rs,
                              output logic [DATA_W-1:0] v, output logic [ROB_TAG_W-1:0] t);
        if (rs == 0) begin
            v = 0; t = 0;
        end else if (commit_index == rs && m_tag[rs] != 0 && commit_tag == m_tag[rs]) begin
            v = commit_value; t = 0;
        end else begin
            v = m_val[rs]; t = m_tag[rs];
        end
    endtask

    // One clock of stimulus: drive, queue the expected read, then advance the
    // model to the state after the coming edge.
    task automatic step(input logic rn, input logic ry,
                        input logic [REG_IDX_W-1:0] s1, input logic [REG_IDX_W-1:0] s2,
                        input logic rf, input logic [REG_IDX_W-1:0] d, input logic [ROB_TAG_W-1:0] rt,
                        input logic [REG_IDX_W-1:0] ci, input logic [ROB_TAG_W-1:0] ct,
                        input logic [DATA_W-1:0] cv, input logic xb);
        exp_t e;
        @(posedge clk);
        #1;
        rst = rn; rdy = ry; rs1 = s1; rs2 = s2;
        rename_flag = rf; rd = d; rob_tag = rt;
        commit_index = ci; commit_tag = ct; commit_value = cv; xbp = xb;
        step_id++;
        if (rn) begin
            model_read(s1, e.v1, e.t1);
            model_read(s2, e.v2, e.t2);
            e.id = step_id;
            q.push_back(e);
        end
        if (!rn) begin
            for (int i = 0; i < REG_NUM; i++) begin
                m_val[i] = 0; m_tag[i] = 0;
            end
        end else if (ry) begin
            if (ci != 0) begin
                m_val[ci] = cv;
                if (m_tag[ci] == ct) m_tag[ci] = 0;
            end
            if (xb) begin
                for (int i = 0; i < REG_NUM; i++) m_tag[i] = 0;
            end else if (rf && d != 0) begin
                m_tag[d] = rt;
            end
        end
    endtask

    task automatic idle_read(input logic [REG_IDX_W-1:0] s1, input logic [REG_IDX_W-1:0] s2);
        step(1, 1, s1, s2, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Stimulus.
    initial begin
        rst = 0; rdy = 1; rs1 = 0; rs2 = 0; rename_flag = 0; rd = 0; rob_tag = 0;
        commit_index = 0; commit_tag = 0; commit_value = 0; xbp = 0;
`ifdef REGFILE_DEBUG_EN
        dbg_index = 0;
`endif
        for (int i = 0; i < REG_NUM; i++) begin
            m_val[i] = 0; m_tag[i] = 0;
        end

        // Reset, then read an untouched register and x0.
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_read(5, 0);

        // Rename x3 -> 7, observe tag, commit with same-cycle forward.
        step(1, 1, 3, 0, 1, 3, 7, 0, 0, 0, 0);
        idle_read(3, 0);
        step(1, 1, 3, 3, 0, 0, 0, 3, 7, 32'h1234, 0);
        idle_read(3, 3);

        // Two renames of x4; commit of the older producer keeps the younger tag.
        step(1, 1, 4, 0, 1, 4, 2, 0, 0, 0, 0);
        step(1, 1, 4, 0, 1, 4, 9, 0, 0, 0, 0);
        step(1, 1, 4, 4, 0, 0, 0, 4, 2, 32'hAA, 0);
        idle_read(4, 0);

        // Commit and rename on the same register in one cycle.
        step(1, 1, 6, 0, 1, 6, 5, 0, 0, 0, 0);
        step(1, 1, 6, 0, 1, 6, 8, 6, 5, 32'hBEEF, 0);
        idle_read(6, 0);

        // Flush with concurrent commit and rename.
        step(1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 2, 2, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 3, 3, 0, 0, 0, 0);
        idle_read(1, 2);
        step(1, 1, 3, 2, 1, 2, 4, 1, 1, 32'h55, 1);
        idle_read(1, 2);
        idle_read(3, 0);

        // Writes to x0 are discarded; rdy low freezes state.
        step(1, 1, 0, 0, 1, 0, 3, 0, 3, 32'hDEAD, 0);
        idle_read(0, 0);
        step(1, 0, 7, 0, 1, 7, 1, 7, 0, 32'h77, 0);
        idle_read(7, 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic                 r_n, r_y, r_f, r_x;
            logic [REG_IDX_W-1:0] r_s1, r_s2, r_d, r_ci;
            logic [ROB_TAG_W-1:0] r_t, r_ct;
            logic [DATA_W-1:0]    r_cv;
            r_n  = ($urandom_range(0, 299) != 0);
            r_y  = ($urandom_range(0, 7) != 0);
            r_s1 = REG_IDX_W'($urandom_range(0, REG_NUM - 1));
            r_s2 = REG_IDX_W'($urandom_range(0, REG_NUM - 1));
            r_f  = ($urandom_range(0, 1) == 1);
            r_d  = REG_IDX_W'($urandom_range(0, REG_NUM - 1));
            r_t  = ROB_TAG_W'($urandom_range(1, (1 << ROB_TAG_W) - 1));
            r_ci = ($urandom_range(0, 2) == 0) ? '0 : REG_IDX_W'($urandom_range(0, REG_NUM - 1));
            r_ct = ($urandom_range(0, 3) != 0) ? m_tag[r_ci]
                                               : ROB_TAG_W'($urandom_range(0, (1 << ROB_TAG_W) - 1));
            r_cv = $urandom;
            r_x  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) r_s1 = r_ci;
            step(r_n, r_y, r_s1, r_s2, r_f, r_d, r_t, r_ci, r_ct, r_cv, r_x);
        end

        @(posedge clk);
        #1;
        stim_done = 1'b1;
    end

    // Monitor: every expected read is compared while its inputs are held.
    initial begin
        exp_t e;
        int   drain = 0;
        while (!(stim_done && q.size() == 0) && drain < 20) begin
            @(negedge clk);
            if (stim_done) drain++;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (value1 !== e.v1) begin
                    errors++;
                    $display("FAIL value1 step %0d: got %h expected %h", e.id, value1, e.v1);
                end
                checks++;
                if (tag1 !== e.t1) begin
                    errors++;
                    $display("FAIL tag1 step %0d: got %0d expected %0d", e.id, tag1, e.t1);
                end
                checks++;
                if (value2 !== e.v2) begin
                    errors++;
                    $display("FAIL value2 step %0d: got %h expected %h", e.id, value2, e.v2);
                end
                checks++;
                if (tag2 !== e.t2) begin
                    errors++;
                    $display("FAIL tag2 step %0d: got %0d expected %0d", e.id, tag2, e.t2);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected reads left unchecked, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop if the run never completes.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
